// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction timer.
//   state_e          : FSM state encoding (IDLE, WAIT, LIT, REPORT)
//   WIDTH_DEF        : default counter / result width
//   PRESCALE_DEF     : default clk cycles per tick (50 MHz / 50000 = 1 ms)
//   TIMEOUT_DEF      : default ticks allowed for a response
package reaction_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int PRESCALE_DEF = 50000;
  localparam int TIMEOUT_DEF  = 2000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LIT    = 2'd2,
    ST_REPORT = 2'd3
  } state_e;

endpackage

// File: rtl/reaction_timer_tick_gen.sv
// tick_gen: prescaler producing a one-cycle tick every PRESCALE clk cycles.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   run  : count enable; run=0 synchronously clears the prescaler
//   tick : high while the prescaler holds PRESCALE-1
// tick is decoded from the prescaler register alone, so it never depends
// combinationally on run; the consumer only looks at it while running.
module tick_gen
  import reaction_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_q, pre_d;

  assign tick = (pre_q == PW'(PRESCALE - 1));

  always_comb begin
    pre_d = pre_q;
    if (!run) begin
      pre_d = '0;
    end else if (tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: measures the time between a stimulus LED and a button press.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : one-cycle trial request, accepted only in IDLE
//   delay     : stimulus delay in ticks, latched on an accepted start
//   button    : response level (already synchronised / debounced)
//   outled    : stimulus LED, high only in LIT
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse in the REPORT cycle
//   early     : false start flag (button during WAIT)
//   timeout   : no response within TIMEOUT ticks
//   rtime     : reaction time in ticks, held until the next accepted start
//   dbg_state : current FSM state, for observation only
// Handshake: start is a single-cycle strobe with no ready; it is consumed
// only when busy=0 and silently dropped otherwise. done is a single-cycle
// strobe; early/timeout/rtime are valid from done until the next accepted start.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int PRESCALE = PRESCALE_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] delay,
  input  logic             button,
  output logic             outled,
  output logic             busy,
  output logic             done,
  output logic             early,
  output logic             timeout,
  output logic [WIDTH-1:0] rtime,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] delay_q, delay_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rtime_q, rtime_d;
  logic             outled_q, outled_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             early_q, early_d;
  logic             timeout_q, timeout_d;

  logic             tick;
  logic             run;
  logic             to_lit;
  logic [WIDTH-1:0] cnt_inc;

  // The prescaler is held in clear on the WAIT->LIT edge so the LIT phase
  // starts from a fresh tick period.
  assign run = ((state_q == ST_WAIT) || (state_q == ST_LIT)) && !to_lit;

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick)
  );

  // Counter value after this cycle's tick. WAIT compares against this so the
  // LED rises on the very edge the delay-th tick lands (and a delay of 0
  // fires in the first WAIT cycle).
  assign cnt_inc = cnt_q + WIDTH'(tick);

  always_comb begin
    state_d   = state_q;
    delay_d   = delay_q;
    cnt_d     = cnt_q;
    rtime_d   = rtime_q;
    outled_d  = outled_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    early_d   = early_q;
    timeout_d = timeout_q;
    to_lit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d   = ST_WAIT;
          delay_d   = delay;
          cnt_d     = '0;
          rtime_d   = '0;
          early_d   = 1'b0;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
        end
      end

      ST_WAIT: begin
        // A press in WAIT beats delay expiry in the same cycle.
        if (button) begin
          state_d = ST_REPORT;
          early_d = 1'b1;
          rtime_d = '0;
          done_d  = 1'b1;
        end else if (cnt_inc == delay_q) begin
          state_d  = ST_LIT;
          outled_d = 1'b1;
          cnt_d    = '0;
          to_lit   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_LIT: begin
        // A press wins over the timeout when both happen in one cycle.
        if (button) begin
          state_d  = ST_REPORT;
          rtime_d  = cnt_q;
          outled_d = 1'b0;
          done_d   = 1'b1;
        end else if (cnt_q == WIDTH'(TIMEOUT)) begin
          state_d   = ST_REPORT;
          timeout_d = 1'b1;
          rtime_d   = WIDTH'(TIMEOUT);
          outled_d  = 1'b0;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        outled_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      cnt_q     <= '0;
      rtime_q   <= '0;
      outled_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      cnt_q     <= cnt_d;
      rtime_q   <= rtime_d;
      outled_q  <= outled_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
    end
  end

  assign outled    = outled_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign early     = early_q;
  assign timeout   = timeout_q;
  assign rtime     = rtime_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Bench for reaction_timer with PRESCALE=4, TIMEOUT=10, WIDTH=8.
// A trial is described by its delay d and the WAIT-relative cycle b at which
// the button goes (and stays) high, b<0 meaning never. The model derives the
// outcome from tick arithmetic; a monitor pops it when done pulses.
module tb_reaction_timer;
  import reaction_pkg::*;

  localparam int W  = 8;
  localparam int P  = 4;
  localparam int T  = 10;
  localparam int EW = 19; // {lit0[7:0], lit, early, timeout, rtime[7:0]}

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] delay;
  logic         button;
  logic         outled;
  logic         busy;
  logic         done;
  logic         early;
  logic         timeout;
  logic [W-1:0] rtime;
  state_e       dbg_state;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];

  reaction_timer #(
    .WIDTH   (W),
    .PRESCALE(P),
    .TIMEOUT (T)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .delay    (delay),
    .button   (button),
    .outled   (outled),
    .busy     (busy),
    .done     (done),
    .early    (early),
    .timeout  (timeout),
    .rtime    (rtime),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // LIT begins at WAIT cycle d*P (the d-th tick lands on cycle d*P-1), or at
  // cycle 1 for d=0. In LIT cycle k the counter reads k/P; the timeout is seen
  // at k=T*P, where a simultaneous press still wins.
  function automatic logic [EW-1:0] model(input int d, input int b);
    int lit0;
    int r;
    bit l, e, t;
    lit0 = (d == 0) ? 1 : d * P;
    if (b >= 0 && b < lit0) begin
      l = 0; e = 1; t = 0; r = 0;
    end else begin
      l = 1; e = 0;
      if (b >= 0 && (b - lit0) <= T * P) begin
        t = 0; r = (b - lit0) / P;
      end else begin
        t = 1; r = T;
      end
    end
    return {8'(lit0), l, e, t, 8'(r)};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  int  cyc = 0;
  int  t0 = 0;
  int  led_dt = 0;
  bit  led_seen = 0;
  bit  prev_busy = 0;
  bit  prev_done = 0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    cyc++;
    if (busy && !prev_busy) begin
      t0       = cyc;
      led_seen = 0;
    end
    if (outled && !led_seen) begin
      led_seen = 1;
      led_dt   = cyc - t0;
    end
    if (done) begin
      chk("done_width", int'(prev_done), 0);
      chk("busy_in_report", int'(busy), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("early", int'(early), int'(e[9]));
        chk("timeout", int'(timeout), int'(e[8]));
        chk("rtime", int'(rtime), int'(e[7:0]));
        chk("led_seen", int'(led_seen), int'(e[10]));
        if (e[10]) chk("led_rise_cycle", led_dt, int'(e[18:11]));
      end
    end
    prev_busy = busy;
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic run_trial(input int d, input int b, input bit junk);
    logic [EW-1:0] e;
    bit got;
    e = model(d, b);
    exp_q.push_back(e);
    @(negedge clk);
    start  = 1'b1;
    delay  = W'(d);
    button = 1'b0;
    got    = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        // start during REPORT must be dropped
        start  = junk;
        delay  = W'($urandom);
        button = 1'b0;
        got    = 1;
        break;
      end
      start  = junk && ($urandom_range(0, 3) == 0);
      delay  = W'($urandom);
      button = (b >= 0 && c >= b);
    end
    chk("trial_done", int'(got), 1);
    @(negedge clk);
    start = 1'b0;
    chk("idle_after_report", int'(busy), 0);
    chk("rtime_held", int'(rtime), int'(e[7:0]));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic reset_in_lit();
    bit saw_led;
    bit saw_done;
    @(negedge clk);
    start  = 1'b1;
    delay  = W'(1);
    button = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    saw_led = 0;
    for (int i = 0; i < 50; i++) begin
      if (outled) begin
        saw_led = 1;
        break;
      end
      @(negedge clk);
    end
    chk("led_before_rst", int'(saw_led), 1);
    // rst must override start and button in the same cycle
    rst    = 1'b1;
    start  = 1'b1;
    button = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    start  = 1'b0;
    button = 1'b0;
    chk("rst_outled", int'(outled), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_early", int'(early), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_rtime", int'(rtime), 0);
    chk("rst_state", int'(dbg_state), int'(ST_IDLE));
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("no_done_after_abort", int'(saw_done), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    delay  = '0;
    button = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_outled", int'(outled), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_done", int'(done), 0);
    chk("init_rtime", int'(rtime), 0);
    chk("init_state", int'(dbg_state), int'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    run_trial(3, 12 + 9, 0);       // rtime 2, LED at WAIT+12
    run_trial(5, 2, 0);            // false start on third WAIT cycle
    run_trial(0, -1, 0);           // immediate LED, timeout
    run_trial(0, 1 + T * P, 0);    // press on the timeout cycle wins
    run_trial(0, T * P, 0);        // press one cycle before: rtime 9
    run_trial(3, 11, 0);           // press on the delay-expiry cycle: early
    run_trial(3, 12, 0);           // press in first LIT cycle: rtime 0
    run_trial(2, 0, 0);            // press in first WAIT cycle
    run_trial(4, 20, 1);           // junk starts during WAIT/LIT/REPORT
    reset_in_lit();
    run_trial(2, 8 + 5, 0);        // normal trial after abort

    for (int i = 0; i < 20; i++) begin
      int d;
      int b;
      d = $urandom_range(0, 6);
      if ($urandom_range(0, 4) == 0) b = -1;
      else b = $urandom_range(0, ((d == 0) ? 1 : d * P) + T * P + 2);
      run_trial(d, b, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
